// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the execution stage (master) and the multi-cycle
// multiply/divide sequencer (slave).
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic [3:0]       alu_ctr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             pipe_en;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] remainder;

  modport master (
    output valid_in, alu_ctr, a, b, flush,
    input  pipe_en, busy, done, result, remainder
  );

  modport slave (
    input  valid_in, alu_ctr, a, b, flush,
    output pipe_en, busy, done, result, remainder
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiply / restoring unsigned divide that stalls the
// pipeline while it runs and pulses done for one cycle with the result.
module muldiv_sequencer #(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] MUL_CODE = 4'd3,
  parameter logic [3:0] DIV_CODE = 4'd4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  muldiv_sequencer_if.slave     bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // op_a: multiplicand (MUL) or dividend/quotient shifter (DIV)
  // op_b: multiplier (MUL) or divisor (DIV); acc: product or partial remainder
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             is_mul_s, is_div_s, start_s, last_s;
  logic [WIDTH-1:0] mul_sum_s;
  logic [WIDTH:0]   div_sh_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] div_rem_s;
  logic [WIDTH-1:0] div_quo_s;
  logic [WIDTH:0]   div_diff_s;

  assign is_mul_s = (bus.alu_ctr == MUL_CODE);
  assign is_div_s = (bus.alu_ctr == DIV_CODE);
  assign start_s  = (state_q == ST_IDLE) & bus.valid_in & ~bus.flush & (is_mul_s | is_div_s);
  assign last_s   = (cnt_q == CNT_LAST);

  assign mul_sum_s  = acc_q + (op_b_q[0] ? op_a_q : {WIDTH{1'b0}});
  // Remainder gets one extra bit so the shift never loses the MSB before the compare
  assign div_sh_s   = {acc_q, op_a_q[WIDTH-1]};
  assign div_diff_s = div_sh_s - {1'b0, op_b_q};
  assign div_ge_s   = (div_sh_s >= {1'b0, op_b_q});
  assign div_rem_s  = div_ge_s ? div_diff_s[WIDTH-1:0] : div_sh_s[WIDTH-1:0];
  assign div_quo_s  = {op_a_q[WIDTH-2:0], div_ge_s};

  // Held high during reset so the pipeline is never frozen by a reset-time start
  assign bus.pipe_en   = ~rst_ni | ~(start_s | (state_q == ST_MUL) | (state_q == ST_DIV));
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.remainder = remainder_q;

  // Next-state, datapath iteration and result capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    remainder_d = remainder_q;

    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            cnt_d  = {CNT_W{1'b0}};
            op_a_d = bus.a;
            op_b_d = bus.b;
            acc_d  = {WIDTH{1'b0}};
            if (is_mul_s) begin
              state_d = ST_MUL;
            end else if (bus.b != {WIDTH{1'b0}}) begin
              state_d = ST_DIV;
            end else begin
              state_d     = ST_DONE;
              result_d    = {WIDTH{1'b1}};
              remainder_d = bus.a;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL: begin
          op_a_d = op_a_q << 1;
          op_b_d = op_b_q >> 1;
          acc_d  = mul_sum_s;
          if (last_s) begin
            state_d     = ST_DONE;
            cnt_d       = {CNT_W{1'b0}};
            result_d    = mul_sum_s;
            remainder_d = {WIDTH{1'b0}};
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DIV: begin
          op_a_d = div_quo_s;
          acc_d  = div_rem_s;
          if (last_s) begin
            state_d     = ST_DONE;
            cnt_d       = {CNT_W{1'b0}};
            result_d    = div_quo_s;
            remainder_d = div_rem_s;
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = ((state_d == ST_MUL) || (state_d == ST_DIV)) ? 1'b1 : 1'b0;
    done_d = (state_d == ST_DONE) ? 1'b1 : 1'b0;
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      op_a_q      <= {WIDTH{1'b0}};
      op_b_q      <= {WIDTH{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      result_q    <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, hand-written
// corner sequences and random operations against an arithmetic reference.
module tb_muldiv_sequencer;

  localparam logic [3:0] MUL = 4'd3;
  localparam logic [3:0] DIV = 4'd4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [31:0] last_res;
  logic [31:0] last_rem;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32), .MUL_CODE(4'd3), .DIV_CODE(4'd4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [31:0] exp_rem;
    int          exp_stall;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [31:0] rem);
    logic [63:0] p;
    if (op == MUL) begin
      p   = 64'(a) * 64'(b);
      res = p[31:0];
      rem = 32'd0;
    end else if (b == 32'd0) begin
      res = 32'hFFFF_FFFF;
      rem = a;
    end else begin
      res = a / b;
      rem = a % b;
    end
  endtask

  // Issue one op (inputs held until done), count stall/busy cycles, check the done cycle
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [31:0] exp_rem,
                        input int exp_stall, input string name);
    int stall = 0;
    int bsy   = 0;
    bit seen  = 1'b0;
    bus.valid_in = 1'b1;
    bus.alu_ctr  = op;
    bus.a        = a;
    bus.b        = b;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        check({name, " pipe_en@done"}, 32'(bus.pipe_en), 32'd1);
        check({name, " busy@done"}, 32'(bus.busy), 32'd0);
        check({name, " result"}, bus.result, exp_res);
        check({name, " remainder"}, bus.remainder, exp_rem);
        break;
      end
      if (!bus.pipe_en) stall++;
      if (bus.busy) bsy++;
      @(posedge clk); #1;
    end
    check({name, " done seen"}, 32'(seen), 32'd1);
    check({name, " stall cycles"}, 32'(stall), 32'(exp_stall));
    check({name, " busy cycles"}, 32'(bsy), 32'(exp_stall - 1));
    last_res = exp_res;
    last_rem = exp_rem;
    @(posedge clk); #1;
  endtask

  task automatic idle_check(input string name);
    bus.valid_in = 1'b0;
    bus.alu_ctr  = 4'd0;
    @(negedge clk);
    check({name, " idle done"}, 32'(bus.done), 32'd0);
    check({name, " idle busy"}, 32'(bus.busy), 32'd0);
    check({name, " idle pipe_en"}, 32'(bus.pipe_en), 32'd1);
    @(posedge clk); #1;
  endtask

  vec_t vecs[$];

  initial begin
    logic [3:0]  op;
    logic [31:0] ra, rb, er, em;
    bit          saw;
    n_cmp = 0;
    n_err = 0;

    vecs.push_back('{MUL, 32'd7,          32'd6,  32'd42,         32'd0,      33, "mul 7x6"});
    vecs.push_back('{MUL, 32'hFFFF_FFFF,  32'd2,  32'hFFFF_FFFE,  32'd0,      33, "mul trunc"});
    vecs.push_back('{MUL, 32'd0,          32'd99, 32'd0,          32'd0,      33, "mul zero"});
    vecs.push_back('{DIV, 32'd100,        32'd7,  32'd14,         32'd2,      33, "div 100/7"});
    vecs.push_back('{DIV, 32'd5,          32'd9,  32'd0,          32'd5,      33, "div 5/9"});
    vecs.push_back('{DIV, 32'hFFFF_FFFF,  32'd1,  32'hFFFF_FFFF,  32'd0,      33, "div max/1"});
    vecs.push_back('{DIV, 32'hFFFF_FFFF,  32'h8000_0000, 32'd1,   32'h7FFF_FFFF, 33, "div msb"});
    vecs.push_back('{DIV, 32'h0000_1234,  32'd0,  32'hFFFF_FFFF,  32'h1234,   1,  "div by zero"});

    // Reset with a MUL already presented: outputs clear and the pipe stays enabled
    rst_n        = 1'b0;
    bus.valid_in = 1'b1;
    bus.alu_ctr  = MUL;
    bus.a        = 32'd7;
    bus.b        = 32'd6;
    bus.flush    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset remainder", bus.remainder, 32'd0);
    check("reset pipe_en", 32'(bus.pipe_en), 32'd1);
    bus.valid_in = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_rem,
             vecs[i].exp_stall, vecs[i].name);
      idle_check(vecs[i].name);
    end

    // Back-to-back: second MUL presented the cycle right after done
    run_op(MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd0, 33, "b2b first");
    run_op(MUL, 32'd3, 32'd5, 32'd15, 32'd0, 33, "b2b second");
    idle_check("b2b");

    for (int i = 0; i < 24; i++) begin
      op = ($urandom_range(0, 1) == 0) ? MUL : DIV;
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
      model(op, ra, rb, er, em);
      run_op(op, ra, rb, er, em, (op == DIV && rb == 32'd0) ? 1 : 33, "random");
      if ($urandom_range(0, 1) == 0) idle_check("random");
    end
    idle_check("random end");

    // Flush during DIV iteration 10: abort, keep previous result, no done pulse
    bus.valid_in = 1'b1;
    bus.alu_ctr  = DIV;
    bus.a        = 32'd100;
    bus.b        = 32'd7;
    @(posedge clk); #1;
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    check("flush pre pipe_en", 32'(bus.pipe_en), 32'd0);
    check("flush pre busy", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.valid_in = 1'b0;
    @(negedge clk);
    check("flush busy", 32'(bus.busy), 32'd0);
    check("flush pipe_en", 32'(bus.pipe_en), 32'd1);
    check("flush done", 32'(bus.done), 32'd0);
    check("flush result kept", bus.result, last_res);
    check("flush remainder kept", bus.remainder, last_rem);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) saw = 1'b1;
    end
    check("flush no done pulse", 32'(saw), 32'd0);
    @(posedge clk); #1;

    // Flush in the start cycle suppresses the start
    bus.valid_in = 1'b1;
    bus.alu_ctr  = DIV;
    bus.flush    = 1'b1;
    @(negedge clk);
    check("flush start pipe_en", 32'(bus.pipe_en), 32'd1);
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.valid_in = 1'b0;
    @(negedge clk);
    check("flush start busy", 32'(bus.busy), 32'd0);
    check("flush start done", 32'(bus.done), 32'd0);
    check("flush start pipe_en after", 32'(bus.pipe_en), 32'd1);
    @(posedge clk); #1;

    // Reset at MUL iteration 5 clears everything immediately
    bus.valid_in = 1'b1;
    bus.alu_ctr  = MUL;
    bus.a        = 32'd7;
    bus.b        = 32'd6;
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    check("midrst result", bus.result, 32'd0);
    check("midrst remainder", bus.remainder, 32'd0);
    check("midrst pipe_en", 32'(bus.pipe_en), 32'd1);
    bus.valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Non-MUL/DIV opcode never stalls
    bus.valid_in = 1'b1;
    bus.alu_ctr  = 4'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("add pipe_en", 32'(bus.pipe_en), 32'd1);
      check("add busy", 32'(bus.busy), 32'd0);
      check("add done", 32'(bus.done), 32'd0);
      @(posedge clk); #1;
    end
    bus.valid_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide controller for the execution stage. Detects MUL (ALUctr 3) and DIV (ALUctr 4) in DX. Freezes the pipeline by driving the shared stage enable low. Runs an iterative shift-add multiply or restoring unsigned divide on its own datapath, then presents the result with a one-cycle done pulse, during which the execution stage latches it in place of its own ALU output.

Parameters:
WIDTH, 32, operand/result width in bits
MUL_CODE, 4'd3, ALUctr encoding for multiply
DIV_CODE, 4'd4, ALUctr encoding for unsigned divide

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
valid_in  input  1  DX holds a valid instruction
ALUctr  input  4  ALU operation code from DX
A  input  WIDTH  operand A (dividend / multiplicand)
B  input  WIDTH  operand B (divisor / multiplier)
flush  input  1  synchronous abort (branch/jump squash)
pipe_en  output  1  stage enable to DX/XM/FD registers (combinational)
busy  output  1  operation in progress
done  output  1  one-cycle result-valid pulse
result  output  WIDTH  product low WIDTH bits, or quotient
remainder  output  WIDTH  division remainder (0 after MUL)

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, result=0, remainder=0, counter=0, internal operand regs=0. pipe_en=1 while in reset.
- States: IDLE, MUL, DIV, DONE.
- Start condition: start = state==IDLE & valid_in & ~flush & (ALUctr==MUL_CODE | ALUctr==DIV_CODE).
- pipe_en = ~(start | state==MUL | state==DIV). pipe_en is high in DONE, which lets the stalled instruction advance with the result.
- busy: registered; 1 in MUL/DIV, 0 in IDLE/DONE.
- IDLE -> MUL on start with MUL_CODE. Latch A, B. Clear the accumulator. counter=0.
- IDLE -> DIV on start with DIV_CODE and B!=0. Latch A, B. Clear the partial remainder. counter=0.
- IDLE -> DONE on start with DIV_CODE and B==0 (divide-by-zero):
  - result = all ones, remainder = A.
  - Stall lasts 1 cycle only.
- MUL iteration, one per cycle:
  - if multiplier bit0 = 1, acc += multiplicand;
  - multiplicand <<= 1; multiplier >>= 1;
  - truncate to WIDTH bits (no overflow flag).
- DIV iteration (restoring), one per cycle:
  - {rem, quo} shifted left 1;
  - if rem >= divisor: rem -= divisor and quo[0] = 1.
- Counter: runs 0..WIDTH-1. On the cycle where counter==WIDTH-1, the state goes to DONE and result/remainder are written.
- Latency: start cycle at edge 0, WIDTH iteration cycles, then done=1 during cycle WIDTH+1. pipe_en is low for exactly WIDTH+1 cycles (33 at default).
- DONE:
  - done=1 for exactly one cycle, then unconditional return to IDLE.
  - No start is possible in DONE, so a stale ALUctr does not retrigger.
  - A new MUL/DIV in the following cycle starts normally.
- result/remainder hold their values until the next completion, reset, or flush.
- flush, synchronous, highest priority after reset:
  - any state -> IDLE; done=0, busy=0.
  - Partial results are discarded; result/remainder are unchanged.
  - flush in the start cycle suppresses the start (pipe_en stays 1).
- Reset asserted mid-operation: immediate return to the reset values. No done pulse.
- Non-MUL/DIV ALUctr or valid_in=0: block stays IDLE and pipe_en=1.

Test Plan:
- MUL A=7, B=6 -> pipe_en low 33 cycles; done pulse with result=42, remainder=0; pipe_en=1 in the done cycle; IDLE next cycle.
- MUL A=0xFFFFFFFF, B=2 -> result=0xFFFFFFFE (truncated); back-to-back second MUL A=3, B=5 issued the cycle after done -> result=15, with no idle gap required.
- DIV A=100, B=7 -> done after 33 stall cycles; result=14, remainder=2. DIV A=5, B=9 -> result=0, remainder=5.
- DIV A=0x1234, B=0 -> pipe_en low 1 cycle; done next cycle; result=0xFFFFFFFF, remainder=0x1234.
- Start DIV A=100, B=7, assert flush at iteration 10 -> next cycle IDLE, busy=0, pipe_en=1, no done pulse, result keeps its prior value; also flush with start in the same cycle -> no stall.
- Start MUL, drive rst low at iteration 5 -> busy/done/result/remainder=0, pipe_en=1 immediately; ALUctr=0 (add) with valid_in=1 -> pipe_en stays 1, no state change.
